waveform_word_fetcher: RTL and testbench

- Upstream stage of the DAC waveform player.
- On request, DMA-reads a block of 16-bit RAM words and packs them into 20-bit DAC samples.
- Stores the samples in a local block RAM buffer.
- Serves the samples one at a time over the word_next/word_ok/word_last/word_rst handshake that the waveform player consumes.

---
 rtl/waveform_word_fetcher_pkg.sv | 22 ++
 rtl/waveform_sample_ram.sv | 28 ++
 rtl/waveform_word_fetcher.sv | 223 ++++++++++++++++++++++
 tb/tb_waveform_word_fetcher.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/waveform_word_fetcher_pkg.sv
// Shared definitions for the waveform word fetcher: fill FSM encoding and the
// sample-count / address-increment constants also used by the waveform player.
package waveform_word_fetcher_pkg;

  localparam int WFF_WORD_WID      = 20;
  localparam int WFF_WORD_AMNT_WID = 11;
  localparam int WFF_WORD_AMNT     = 2047;
  localparam int WFF_RAM_WID       = 32;
  localparam int WFF_RAM_WORD_WID  = 16;
  localparam int WFF_RAM_WORD_INCR = 2;

  typedef enum logic [2:0] {
    FILL_IDLE    = 3'd0,
    FILL_REQ_LO  = 3'd1,
    FILL_WAIT_LO = 3'd2,
    FILL_REQ_HI  = 3'd3,
    FILL_WAIT_HI = 3'd4,
    FILL_STORE   = 3'd5,
    FILL_DONE    = 3'd6
  } fill_state_e;

endpackage

// File: rtl/waveform_sample_ram.sv
// Simple dual-port sample buffer: one write port, one read port with a
// registered (one-cycle) read. Kept reset-free so it maps onto block RAM.
module waveform_sample_ram #(
  parameter int DATA_WID = 20,
  parameter int ADDR_WID = 11
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_WID-1:0] waddr,
  input  logic [DATA_WID-1:0] wdata,
  input  logic                re,
  input  logic [ADDR_WID-1:0] raddr,
  output logic [DATA_WID-1:0] rdata
);

  logic [DATA_WID-1:0] mem_q [0:(1 << ADDR_WID)-1];

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem_q[raddr];
    end
  end

endmodule

// File: rtl/waveform_word_fetcher.sv
// DMA-fills a sample buffer from 16-bit RAM words (two words per sample, low
// first) and serves samples over the word_next/word_ok handshake.
module waveform_word_fetcher
  import waveform_word_fetcher_pkg::*;
#(
  parameter int WORD_WID      = WFF_WORD_WID,
  parameter int WORD_AMNT_WID = WFF_WORD_AMNT_WID,
  parameter int WORD_AMNT     = WFF_WORD_AMNT,
  parameter int RAM_WID       = WFF_RAM_WID,
  parameter int RAM_WORD_WID  = WFF_RAM_WORD_WID,
  parameter int RAM_WORD_INCR = WFF_RAM_WORD_INCR
) (
  input  logic                    clk,
  input  logic                    rst_L,
  input  logic                    refresh_start,
  input  logic [RAM_WID-1:0]      start_addr,
  output logic                    refresh_finished,
  output logic [RAM_WID-1:0]      ram_dma_addr,
  output logic                    ram_read,
  input  logic [RAM_WORD_WID-1:0] ram_word,
  input  logic                    ram_valid,
  output logic [WORD_WID-1:0]     word,
  input  logic                    word_next,
  output logic                    word_ok,
  output logic                    word_last,
  input  logic                    word_rst
);

  localparam int HI_KEEP = WORD_WID - RAM_WORD_WID;
  localparam logic [WORD_AMNT_WID-1:0] LAST_IDX  = WORD_AMNT_WID'(WORD_AMNT);
  localparam logic [RAM_WID-1:0]       ADDR_INCR = RAM_WID'(RAM_WORD_INCR);

  fill_state_e               state_q, state_d;
  logic [RAM_WID-1:0]        addr_q, addr_d;
  logic [RAM_WID-1:0]        dma_addr_q, dma_addr_d;
  logic                      ram_read_q, ram_read_d;
  logic [RAM_WORD_WID-1:0]   lo_q, lo_d;
  logic [HI_KEEP-1:0]        hi_q, hi_d;
  logic [WORD_AMNT_WID-1:0]  wptr_q, wptr_d;
  logic                      fin_q, fin_d;
  logic [WORD_AMNT_WID-1:0]  rptr_q, rptr_d;
  logic                      pend_q, pend_d;
  logic                      word_ok_q, word_ok_d;
  logic                      word_last_q, word_last_d;
  logic [WORD_WID-1:0]       word_q, word_d;

  logic                      ram_we_s;
  logic                      rd_en_s;
  logic                      rptr_clr_s;
  logic [WORD_WID-1:0]       wr_data_s;
  logic [WORD_WID-1:0]       rd_data_s;

  assign wr_data_s = {hi_q, lo_q};

  waveform_sample_ram #(
    .DATA_WID (WORD_WID),
    .ADDR_WID (WORD_AMNT_WID)
  ) u_sample_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (wptr_q),
    .wdata (wr_data_s),
    .re    (rd_en_s),
    .raddr (rptr_q),
    .rdata (rd_data_s)
  );

  // Fill FSM: next state, DMA request/address and sample assembly.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    dma_addr_d = dma_addr_q;
    ram_read_d = ram_read_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    wptr_d     = wptr_q;
    fin_d      = fin_q;
    ram_we_s   = 1'b0;
    rptr_clr_s = 1'b0;
    case (state_q)
      FILL_IDLE: begin
        // A refresh waits for any serve in flight to finish its handshake.
        if (refresh_start && !word_ok_q && !pend_q) begin
          addr_d  = start_addr;
          wptr_d  = '0;
          state_d = FILL_REQ_LO;
        end else begin
          state_d = FILL_IDLE;
        end
      end
      FILL_REQ_LO: begin
        dma_addr_d = addr_q;
        ram_read_d = 1'b1;
        state_d    = FILL_WAIT_LO;
      end
      FILL_WAIT_LO: begin
        if (ram_valid) begin
          lo_d       = ram_word;
          ram_read_d = 1'b0;
          addr_d     = addr_q + ADDR_INCR;
          state_d    = FILL_REQ_HI;
        end else begin
          state_d = FILL_WAIT_LO;
        end
      end
      FILL_REQ_HI: begin
        dma_addr_d = addr_q;
        ram_read_d = 1'b1;
        state_d    = FILL_WAIT_HI;
      end
      FILL_WAIT_HI: begin
        if (ram_valid) begin
          hi_d       = ram_word[HI_KEEP-1:0];
          ram_read_d = 1'b0;
          addr_d     = addr_q + ADDR_INCR;
          state_d    = FILL_STORE;
        end else begin
          state_d = FILL_WAIT_HI;
        end
      end
      FILL_STORE: begin
        ram_we_s = 1'b1;
        if (wptr_q == LAST_IDX) begin
          fin_d   = 1'b1;
          state_d = FILL_DONE;
        end else begin
          wptr_d  = wptr_q + WORD_AMNT_WID'(1);
          state_d = FILL_REQ_LO;
        end
      end
      FILL_DONE: begin
        if (!refresh_start) begin
          fin_d      = 1'b0;
          rptr_clr_s = 1'b1;
          state_d    = FILL_IDLE;
        end else begin
          state_d = FILL_DONE;
        end
      end
      default: begin
        ram_read_d = 1'b0;
        fin_d      = 1'b0;
        state_d    = FILL_IDLE;
      end
    endcase
  end

  // Serve handshake: issue buffer read, present sample two cycles later,
  // advance the read pointer when the consumer releases word_next.
  always_comb begin
    rptr_d      = rptr_q;
    pend_d      = 1'b0;
    word_ok_d   = word_ok_q;
    word_last_d = word_last_q;
    word_d      = word_q;
    rd_en_s     = 1'b0;
    if (word_rst) begin
      rptr_d    = '0;
      word_ok_d = 1'b0;
    end else if (rptr_clr_s) begin
      rptr_d = '0;
    end else if (state_q != FILL_IDLE) begin
      word_ok_d = 1'b0;
    end else if (pend_q) begin
      word_d      = rd_data_s;
      word_ok_d   = 1'b1;
      word_last_d = (rptr_q == LAST_IDX);
    end else if (word_ok_q) begin
      if (!word_next) begin
        word_ok_d = 1'b0;
        rptr_d    = (rptr_q == LAST_IDX) ? '0 : rptr_q + WORD_AMNT_WID'(1);
      end else begin
        word_ok_d = 1'b1;
      end
    end else if (word_next && !refresh_start) begin
      rd_en_s = 1'b1;
      pend_d  = 1'b1;
    end else begin
      word_ok_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q     <= FILL_IDLE;
      addr_q      <= '0;
      dma_addr_q  <= '0;
      ram_read_q  <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
      wptr_q      <= '0;
      fin_q       <= 1'b0;
      rptr_q      <= '0;
      pend_q      <= 1'b0;
      word_ok_q   <= 1'b0;
      word_last_q <= 1'b0;
      word_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      dma_addr_q  <= dma_addr_d;
      ram_read_q  <= ram_read_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      wptr_q      <= wptr_d;
      fin_q       <= fin_d;
      rptr_q      <= rptr_d;
      pend_q      <= pend_d;
      word_ok_q   <= word_ok_d;
      word_last_q <= word_last_d;
      word_q      <= word_d;
    end
  end

  assign refresh_finished = fin_q;
  assign ram_dma_addr     = dma_addr_q;
  assign ram_read         = ram_read_q;
  assign word             = word_q;
  assign word_ok          = word_ok_q;
  assign word_last        = word_last_q;

endmodule

// File: tb/tb_waveform_word_fetcher.sv
// Self-checking bench for waveform_word_fetcher with a 4-sample buffer, a
// behavioural DMA responder and a packing/serve reference model.
module tb_waveform_word_fetcher;

  localparam int NS = 4;

  logic        clk = 1'b0;
  logic        rst_L;
  logic        refresh_start;
  logic [31:0] start_addr;
  logic        refresh_finished;
  logic [31:0] ram_dma_addr;
  logic        ram_read;
  logic [15:0] ram_word;
  logic        ram_valid;
  logic [19:0] word;
  logic        word_next;
  logic        word_ok;
  logic        word_last;
  logic        word_rst;

  waveform_word_fetcher #(
    .WORD_AMNT_WID (4),
    .WORD_AMNT     (NS - 1)
  ) dut (
    .clk              (clk),
    .rst_L            (rst_L),
    .refresh_start    (refresh_start),
    .start_addr       (start_addr),
    .refresh_finished (refresh_finished),
    .ram_dma_addr     (ram_dma_addr),
    .ram_read         (ram_read),
    .ram_word         (ram_word),
    .ram_valid        (ram_valid),
    .word             (word),
    .word_next        (word_next),
    .word_ok          (word_ok),
    .word_last        (word_last),
    .word_rst         (word_rst)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] mem [logic [31:0]];
  logic [31:0] dma_log [$];
  int          rd_count    = 0;
  int          stall_idx   = -1;
  int          stall_len   = 0;
  int          stall_cycles = 0;
  int          stall_bad   = 0;
  bit          rand_dly    = 1'b0;
  int          rst_epoch   = 0;
  int          ok_seen     = 0;

  logic [19:0] model_buf [NS];
  int          model_rptr = 0;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] data;
  } mem_vec_t;

  typedef struct {
    bit          rewind;
    logic [19:0] exp_word;
    bit          exp_last;
    int          hold;
  } serve_vec_t;

  mem_vec_t   fixed_mem [8];
  serve_vec_t svec [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Sample k is {bits[3:0] of the word at base+4k+2, word at base+4k}.
  task automatic build_model(input logic [31:0] base);
    for (int k = 0; k < NS; k++) begin
      logic [15:0] lo;
      logic [15:0] hi;
      lo = mem[base + 32'(4 * k)];
      hi = mem[base + 32'(4 * k + 2)];
      model_buf[k] = {hi[3:0], lo};
    end
  endtask

  task automatic fill_random_mem(input logic [31:0] base);
    for (int i = 0; i < 2 * NS; i++) begin
      mem[base + 32'(2 * i)] = 16'($urandom);
    end
  endtask

  always @(negedge rst_L) rst_epoch <= rst_epoch + 1;

  // DMA responder: answers each read after a programmable delay.
  initial begin : dma_resp
    logic [31:0] a;
    int          d;
    int          ep;
    bit          is_stall;
    ram_valid = 1'b0;
    ram_word  = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst_L === 1'b1 && ram_read === 1'b1) begin
        a  = ram_dma_addr;
        ep = rst_epoch;
        dma_log.push_back(a);
        is_stall = (rd_count == stall_idx);
        if (is_stall) d = stall_len;
        else if (rand_dly) d = int'($urandom_range(3, 0));
        else d = 0;
        rd_count++;
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          if (rst_epoch != ep) break;
          if (is_stall) begin
            stall_cycles++;
            if (!(ram_read === 1'b1 && ram_dma_addr === a)) stall_bad++;
          end
        end
        if (rst_epoch == ep) begin
          ram_word  = mem.exists(a) ? mem[a] : 16'h0000;
          ram_valid = 1'b1;
          @(negedge clk);
          ram_valid = 1'b0;
          ram_word  = 16'h0000;
        end
      end
    end
  end

  task automatic do_fill(input logic [31:0] base);
    dma_log.delete();
    rd_count      = 0;
    ok_seen       = 0;
    start_addr    = base;
    refresh_start = 1'b1;
    for (int i = 0; i < 3000 && refresh_finished !== 1'b1; i++) begin
      @(negedge clk);
      if (word_ok === 1'b1) ok_seen++;
    end
    check("fill_done", 32'(refresh_finished), 32'd1);
    check("fill_reads", 32'(dma_log.size()), 32'(2 * NS));
    for (int i = 0; i < dma_log.size() && i < 2 * NS; i++) begin
      check("fill_addr", dma_log[i], base + 32'(2 * i));
    end
    refresh_start = 1'b0;
    #1;
    check("fin_hold", 32'(refresh_finished), 32'd1);
    @(negedge clk);
    check("fin_fall", 32'(refresh_finished), 32'd0);
    build_model(base);
    model_rptr = 0;
  endtask

  task automatic serve(input logic [19:0] ew, input bit el, input int hold, input string tag);
    word_next = 1'b1;
    @(negedge clk);
    check({tag, "_ok_early"}, 32'(word_ok), 32'd0);
    @(negedge clk);
    check({tag, "_ok"}, 32'(word_ok), 32'd1);
    check({tag, "_word"}, 32'(word), 32'(ew));
    check({tag, "_last"}, 32'(word_last), 32'(el));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_ok_hold"}, 32'(word_ok), 32'd1);
    end
    word_next = 1'b0;
    @(negedge clk);
    check({tag, "_ok_drop"}, 32'(word_ok), 32'd0);
  endtask

  task automatic serve_model(input int hold, input string tag);
    serve(model_buf[model_rptr], model_rptr == NS - 1, hold, tag);
    model_rptr = (model_rptr + 1) % NS;
  endtask

  initial begin
    fixed_mem[0] = '{32'h100, 16'h1234};
    fixed_mem[1] = '{32'h102, 16'h000A};
    fixed_mem[2] = '{32'h104, 16'h5678};
    fixed_mem[3] = '{32'h106, 16'h000B};
    fixed_mem[4] = '{32'h108, 16'h9ABC};
    fixed_mem[5] = '{32'h10A, 16'hFFFC};
    fixed_mem[6] = '{32'h10C, 16'hDEF0};
    fixed_mem[7] = '{32'h10E, 16'h0001};
    svec[0] = '{1'b0, 20'hA1234, 1'b0, 0};
    svec[1] = '{1'b0, 20'hB5678, 1'b0, 2};
    svec[2] = '{1'b0, 20'hC9ABC, 1'b0, 0};
    svec[3] = '{1'b0, 20'h1DEF0, 1'b1, 1};
    svec[4] = '{1'b0, 20'hA1234, 1'b0, 0};
    svec[5] = '{1'b0, 20'hB5678, 1'b0, 0};
    svec[6] = '{1'b1, 20'hA1234, 1'b0, 0};
    for (int i = 0; i < 8; i++) mem[fixed_mem[i].addr] = fixed_mem[i].data;

    rst_L = 1'b0; refresh_start = 1'b0; start_addr = 32'h0;
    word_next = 1'b0; word_rst = 1'b0;
    repeat (3) @(negedge clk);
    rst_L = 1'b1;
    @(negedge clk);
    check("rst_ram_read", 32'(ram_read), 32'd0);
    check("rst_dma_addr", ram_dma_addr, 32'd0);
    check("rst_fin", 32'(refresh_finished), 32'd0);
    check("rst_word_ok", 32'(word_ok), 32'd0);
    check("rst_word", 32'(word), 32'd0);
    check("rst_word_last", 32'(word_last), 32'd0);

    // Fixed fill at 0x100, then the serve/wrap/rewind table.
    do_fill(32'h100);
    for (int i = 0; i < 7; i++) begin
      if (svec[i].rewind) begin
        word_next = 1'b1;
        word_rst  = 1'b1;
        @(negedge clk);
        word_rst  = 1'b0;
        word_next = 1'b0;
        check("rewind_ok0", 32'(word_ok), 32'd0);
        @(negedge clk);
        check("rewind_ok1", 32'(word_ok), 32'd0);
      end
      serve(svec[i].exp_word, svec[i].exp_last, svec[i].hold, $sformatf("tbl%0d", i));
    end

    // Refresh raised while word_ok is high waits; the refill stalls on read 3.
    stall_idx = 2; stall_len = 10; stall_cycles = 0; stall_bad = 0;
    start_addr = 32'h100;
    word_next = 1'b1;
    for (int i = 0; i < 5 && word_ok !== 1'b1; i++) @(negedge clk);
    check("defer_ok", 32'(word_ok), 32'd1);
    refresh_start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("defer_no_read", 32'(ram_read), 32'd0);
    end
    word_next = 1'b0;
    do_fill(32'h100);
    check("stall_cycles", 32'(stall_cycles), 32'd10);
    check("stall_stable", 32'(stall_bad), 32'd0);
    stall_idx = -1;
    serve(20'hA1234, 1'b0, 0, "post_stall");
    model_rptr = 1;

    // word_next held through a fill: no word_ok until back in IDLE, then index 0.
    rand_dly = 1'b1;
    fill_random_mem(32'h300);
    word_next = 1'b1;
    do_fill(32'h300);
    check("gate_ok_during_fill", 32'(ok_seen), 32'd0);
    for (int i = 0; i < 10 && word_ok !== 1'b1; i++) @(negedge clk);
    check("gate_ok", 32'(word_ok), 32'd1);
    check("gate_word", 32'(word), 32'(model_buf[0]));
    check("gate_last", 32'(word_last), 32'd0);
    word_next = 1'b0;
    @(negedge clk);
    model_rptr = 1;
    serve_model(0, "gate_s1");

    // Async reset during WAIT_HI, then refill at 0x200.
    rand_dly = 1'b0;
    stall_idx = 1; stall_len = 50;
    dma_log.delete(); rd_count = 0;
    start_addr = 32'h100; refresh_start = 1'b1;
    for (int i = 0; i < 50 && dma_log.size() < 2; i++) @(negedge clk);
    check("arst_in_wait_hi", 32'(dma_log.size()), 32'd2);
    @(negedge clk);
    #2;
    rst_L = 1'b0;
    refresh_start = 1'b0;
    #1;
    check("arst_ram_read", 32'(ram_read), 32'd0);
    check("arst_dma_addr", ram_dma_addr, 32'd0);
    check("arst_fin", 32'(refresh_finished), 32'd0);
    check("arst_word_ok", 32'(word_ok), 32'd0);
    check("arst_word", 32'(word), 32'd0);
    check("arst_word_last", 32'(word_last), 32'd0);
    repeat (3) @(negedge clk);
    rst_L = 1'b1;
    stall_idx = -1;
    repeat (3) begin
      @(negedge clk);
      check("arst_idle_read", 32'(ram_read), 32'd0);
    end
    fill_random_mem(32'h200);
    do_fill(32'h200);
    for (int i = 0; i <= NS; i++) serve_model(i % 2, $sformatf("arst_s%0d", i));

    // Randomised fills and serves with occasional rewinds.
    rand_dly = 1'b1;
    for (int r = 0; r < 3; r++) begin
      logic [31:0] base;
      base = 32'($urandom_range(32'h0FFF_FFF0, 32'h0)) & 32'hFFFF_FFFE;
      fill_random_mem(base);
      do_fill(base);
      for (int j = 0; j < 7; j++) begin
        if ($urandom_range(4, 0) == 0) begin
          word_rst = 1'b1;
          @(negedge clk);
          word_rst = 1'b0;
          model_rptr = 0;
          check("rnd_rewind_ok", 32'(word_ok), 32'd0);
        end
        serve_model(int'($urandom_range(2, 0)), $sformatf("rnd%0d_%0d", r, j));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
